// File: rtl/user_counter_array.sv
// user_counter_array: Wishbone slave holding NUM_CH independent up/down
// counters with compare match, auto-reload, match IRQ and LA freeze.
//
// Ports:
//   wb_clk_i/wb_rst_i   clock, async active-high reset
//   wbs_*               Wishbone classic slave (1-cycle ack, ack gap)
//   la_data_in/la_oenb  bit 0 freezes all channels when driven high
//   la_data_out         ch0 COUNT at [CNT_W-1:0], match flags at [64+]
//   io_in/io_out/io_oeb ch0 COUNT on pads, always driven
//   irq                 irq[0] = registered OR of enabled match flags
//
// Register map per channel (adr[7:5] = ch, adr[4:2] = reg):
//   0 CTRL {down, irq_en, auto_reload, enable}  1 COUNT  2 COMPARE
//   3 STATUS {match, W1C}  4 PRESCALE
//
// Optional: define USER_COUNTER_PRESCALE_EN for per-channel prescalers.

module user_counter_array #(
  parameter int          NUM_CH   = 4,
  parameter int          CNT_W    = 16,
  parameter int          IO_BITS  = 16,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wbs_cyc_i,
  input  logic               wbs_stb_i,
  input  logic               wbs_we_i,
  input  logic [3:0]         wbs_sel_i,
  input  logic [31:0]        wbs_adr_i,
  input  logic [31:0]        wbs_dat_i,
  output logic               wbs_ack_o,
  output logic [31:0]        wbs_dat_o,
  input  logic [127:0]       la_data_in,
  input  logic [127:0]       la_oenb,
  output logic [127:0]       la_data_out,
  input  logic [IO_BITS-1:0] io_in,
  output logic [IO_BITS-1:0] io_out,
  output logic [IO_BITS-1:0] io_oeb,
  output logic [2:0]         irq
);

  localparam logic [2:0] R_CTRL  = 3'd0;
  localparam logic [2:0] R_COUNT = 3'd1;
  localparam logic [2:0] R_CMP   = 3'd2;
  localparam logic [2:0] R_STAT  = 3'd3;
  localparam logic [2:0] R_PRESC = 3'd4;

  localparam logic [3:0] NUM_L = 4'(NUM_CH);

  logic             hit;
  logic [2:0]       ch_sel;
  logic [2:0]       reg_sel;
  logic             ch_ok;
  logic             reg_ok;
  logic             ack_q;
  logic             irq_q;
  logic             wr_en;
  logic             freeze;
  logic [31:0]      bmask;
  logic [CNT_W-1:0] wmask;
  logic [CNT_W-1:0] wdat;
  logic [31:0]      rd_sel;

  logic [NUM_CH-1:0][31:0]      rd_ch;
  logic [NUM_CH-1:0][CNT_W-1:0] cnt_all;
  logic [NUM_CH-1:0]            match;
  logic [NUM_CH-1:0]            irq_src;

  logic [IO_BITS+CNT_W-1:0] cnt_ext;
  logic                     unused_ok;

  assign hit = wbs_cyc_i & wbs_stb_i &
               (wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign ch_sel  = wbs_adr_i[7:5];
  assign reg_sel = wbs_adr_i[4:2];
  assign ch_ok   = {1'b0, ch_sel} < NUM_L;
  assign reg_ok  = reg_sel <= R_PRESC;

  // Out-of-range accesses still ack, they just never write.
  assign wr_en = ack_q & hit & wbs_we_i & ch_ok & reg_ok;

  assign freeze = ~la_oenb[0] & la_data_in[0];

  assign bmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                  {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign wmask = bmask[CNT_W-1:0];
  assign wdat  = wbs_dat_i[CNT_W-1:0];

  // Ack lands one cycle after the hit; the ~ack_q term forces a
  // low cycle between acks when a master holds stb.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ack_q <= hit & ~ack_q;
      irq_q <= |irq_src;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [3:0]       ctrl_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cmp_q;
    logic [CNT_W-1:0] ps_rd;
    logic             match_q;
    logic             sel_ch;
    logic             w_ctrl;
    logic             w_cnt;
    logic             w_cmp;
    logic             w_clr;
    logic             run;
    logic             tick;
    logic             step;
    logic             at_cmp;
    logic [31:0]      rd_v;

    assign sel_ch = wr_en & (ch_sel == 3'(i));
    assign w_ctrl = sel_ch & (reg_sel == R_CTRL);
    assign w_cnt  = sel_ch & (reg_sel == R_COUNT);
    assign w_cmp  = sel_ch & (reg_sel == R_CMP);
    assign w_clr  = sel_ch & (reg_sel == R_STAT) &
                    wbs_sel_i[0] & wbs_dat_i[0];

    assign run    = ctrl_q[0] & ~freeze;
    assign at_cmp = cnt_q == cmp_q;
    // A bus write to COUNT swallows the tick of that cycle.
    assign step   = tick & ~w_cnt;

`ifdef USER_COUNTER_PRESCALE_EN
    logic [CNT_W-1:0] ps_q;
    logic [CNT_W-1:0] pc_q;
    logic             w_ps;

    assign w_ps  = sel_ch & (reg_sel == R_PRESC);
    assign tick  = run & (pc_q == ps_q);
    assign ps_rd = ps_q;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
        ps_q <= '0;
        pc_q <= '0;
      end else begin
        if (w_ps)
          ps_q <= (ps_q & ~wmask) | (wdat & wmask);
        if (w_ps | w_cnt)
          pc_q <= '0;
        else if (run)
          pc_q <= tick ? '0 : pc_q + CNT_W'(1);
      end
    end
`else
    assign tick  = run;
    assign ps_rd = '0;
`endif

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
        ctrl_q  <= '0;
        cnt_q   <= '0;
        cmp_q   <= '0;
        match_q <= 1'b0;
      end else begin
        if (w_ctrl)
          ctrl_q <= (ctrl_q & ~wmask[3:0]) |
                    (wdat[3:0] & wmask[3:0]);
        else if (step & at_cmp & ~ctrl_q[1])
          ctrl_q[0] <= 1'b0;

        if (w_cmp)
          cmp_q <= (cmp_q & ~wmask) | (wdat & wmask);

        if (w_cnt)
          cnt_q <= (cnt_q & ~wmask) | (wdat & wmask);
        else if (step) begin
          if (at_cmp) begin
            if (ctrl_q[1])
              cnt_q <= ctrl_q[3] ? '1 : '0;
          end else if (ctrl_q[3])
            cnt_q <= cnt_q - CNT_W'(1);
          else
            cnt_q <= cnt_q + CNT_W'(1);
        end

        // Set beats a coincident W1C.
        if (step & at_cmp)
          match_q <= 1'b1;
        else if (w_clr)
          match_q <= 1'b0;
      end
    end

    always_comb begin
      rd_v = '0;
      unique case (reg_sel)
        R_CTRL:  rd_v = 32'(ctrl_q);
        R_COUNT: rd_v = 32'(cnt_q);
        R_CMP:   rd_v = 32'(cmp_q);
        R_STAT:  rd_v = 32'(match_q);
        R_PRESC: rd_v = 32'(ps_rd);
        default: rd_v = '0;
      endcase
    end

    assign rd_ch[i]   = rd_v;
    assign cnt_all[i] = cnt_q;
    assign match[i]   = match_q;
    assign irq_src[i] = match_q & ctrl_q[2];
  end

  always_comb begin
    rd_sel = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (ch_sel == 3'(k))
        rd_sel = rd_ch[k];
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = (ack_q & hit & ch_ok) ? rd_sel : '0;

  assign irq = {2'b00, irq_q};

  always_comb begin
    la_data_out = '0;
    la_data_out[CNT_W-1:0]   = cnt_all[0];
    la_data_out[64 +: NUM_CH] = match;
  end

  assign cnt_ext = {{IO_BITS{1'b0}}, cnt_all[0]};
  assign io_out  = cnt_ext[IO_BITS-1:0];
  assign io_oeb  = '0;

  assign unused_ok = &{1'b0, io_in, la_data_in[127:1],
                       la_oenb[127:1], wbs_adr_i[1:0],
                       wbs_dat_i, bmask, cnt_all, cnt_ext};

endmodule

// File: tb/tb_user_counter_array.sv
// tb_user_counter_array: directed bench for user_counter_array
// (register table plus hand-written multi-cycle sequences).

module tb_user_counter_array;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam logic [2:0] R_CTRL  = 3'd0;
  localparam logic [2:0] R_COUNT = 3'd1;
  localparam logic [2:0] R_CMP   = 3'd2;
  localparam logic [2:0] R_STAT  = 3'd3;
  localparam logic [2:0] R_PRESC = 3'd4;

`ifdef USER_COUNTER_PRESCALE_EN
  localparam int          GAP    = 3;
  localparam logic [31:0] PS_EXP = 32'd2;
`else
  localparam int          GAP    = 1;
  localparam logic [31:0] PS_EXP = 32'd0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cyc = 1'b0;
  logic         stb = 1'b0;
  logic         we  = 1'b0;
  logic [3:0]   sel = 4'h0;
  logic [31:0]  adr = '0;
  logic [31:0]  wd  = '0;
  logic         ack;
  logic [31:0]  rdat;
  logic [127:0] la_in   = '0;
  logic [127:0] la_oenb = '1;
  logic [127:0] la_out;
  logic [15:0]  io_in   = '0;
  logic [15:0]  io_out;
  logic [15:0]  io_oeb;
  logic [2:0]   irq;

  int checks = 0;
  int errors = 0;

  user_counter_array dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .wbs_cyc_i  (cyc),
    .wbs_stb_i  (stb),
    .wbs_we_i   (we),
    .wbs_sel_i  (sel),
    .wbs_adr_i  (adr),
    .wbs_dat_i  (wd),
    .wbs_ack_o  (ack),
    .wbs_dat_o  (rdat),
    .la_data_in (la_in),
    .la_oenb    (la_oenb),
    .la_data_out(la_out),
    .io_in      (io_in),
    .io_out     (io_out),
    .io_oeb     (io_oeb),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  ch;
    logic [2:0]  rg;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic xfer(input logic [2:0] ch,
                      input logic [2:0] rg,
                      input logic w,
                      input logic [3:0] be,
                      input logic [31:0] d,
                      output logic [31:0] q);
    int lat;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; sel = be;
    adr = {BASE[31:8], ch, rg, 2'b00};
    wd  = d;
    lat = 0;
    q   = '0;
    while (lat < 8) begin
      @(posedge clk); #1;
      lat++;
      if (ack) break;
    end
    if (ack) q = rdat;
    chk("ack_latency", 128'(lat), 128'd1);
    @(posedge clk); #1;
    chk("ack_one_cycle", 128'(ack), 128'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr(input logic [2:0] ch,
                    input logic [2:0] rg,
                    input logic [31:0] d);
    logic [31:0] q;
    xfer(ch, rg, 1'b1, 4'hF, d, q);
  endtask

  task automatic rd(input logic [2:0] ch,
                    input logic [2:0] rg,
                    input string nm,
                    input logic [31:0] exp);
    logic [31:0] q;
    xfer(ch, rg, 1'b0, 4'hF, '0, q);
    chk(nm, 128'(q), 128'(exp));
  endtask

  // Write that lands on the same edge as one unfrozen tick.
  task automatic coincide(input logic [2:0] ch,
                          input logic [2:0] rg,
                          input logic [31:0] d);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF;
    adr = {BASE[31:8], ch, rg, 2'b00};
    wd  = d;
    @(posedge clk); #1;
    chk("coin_ack", 128'(ack), 128'd1);
    @(negedge clk);
    la_in[0] = 1'b0;
    @(posedge clk); #1;
    la_in[0] = 1'b1;
    chk("coin_ack_low", 128'(ack), 128'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic step1();
    @(negedge clk); la_in[0] = 1'b0;
    @(negedge clk); la_in[0] = 1'b1;
  endtask

  initial begin
    logic [15:0]  prev;
    logic [15:0]  cur;
    logic [15:0]  snap;
    logic [127:0] exp_la;
    logic [15:0]  seq[3];
    logic [31:0]  q;
    int bad;
    int last;
    int nch;
    int n;

    vq.push_back('{3'd0, R_CTRL,  1'b0, 4'hF, 32'h0,         32'h0});
    vq.push_back('{3'd2, R_COUNT, 1'b0, 4'hF, 32'h0,         32'h0});
    vq.push_back('{3'd0, R_CMP,   1'b1, 4'hF, 32'h1234,      32'h0});
    vq.push_back('{3'd0, R_CMP,   1'b0, 4'hF, 32'h0,         32'h1234});
    vq.push_back('{3'd0, R_CMP,   1'b1, 4'h0, 32'hFFFF,      32'h0});
    vq.push_back('{3'd0, R_CMP,   1'b0, 4'hF, 32'h0,         32'h1234});
    vq.push_back('{3'd3, R_CTRL,  1'b1, 4'hF, 32'hFFFF_FFFE, 32'h0});
    vq.push_back('{3'd3, R_CTRL,  1'b0, 4'hF, 32'h0,         32'hE});
    vq.push_back('{3'd3, R_COUNT, 1'b1, 4'h3, 32'h1234_5678, 32'h0});
    vq.push_back('{3'd3, R_COUNT, 1'b0, 4'hF, 32'h0,         32'h5678});
    vq.push_back('{3'd3, R_CMP,   1'b1, 4'h1, 32'hAABB_CCDD, 32'h0});
    vq.push_back('{3'd3, R_CMP,   1'b0, 4'hF, 32'h0,         32'hDD});
    vq.push_back('{3'd3, R_CMP,   1'b1, 4'h2, 32'h0000_1100, 32'h0});
    vq.push_back('{3'd3, R_CMP,   1'b0, 4'hF, 32'h0,         32'h11DD});
    vq.push_back('{3'd6, R_CTRL,  1'b0, 4'hF, 32'h0,         32'h0});
    vq.push_back('{3'd6, R_COUNT, 1'b1, 4'hF, 32'hFFFF,      32'h0});
    vq.push_back('{3'd6, R_COUNT, 1'b0, 4'hF, 32'h0,         32'h0});
    vq.push_back('{3'd1, 3'd5,    1'b0, 4'hF, 32'h0,         32'h0});
    vq.push_back('{3'd1, 3'd7,    1'b1, 4'hF, 32'h1234,      32'h0});
    vq.push_back('{3'd1, 3'd7,    1'b0, 4'hF, 32'h0,         32'h0});
    vq.push_back('{3'd1, R_CTRL,  1'b0, 4'hF, 32'h0,         32'h0});
    vq.push_back('{3'd3, R_PRESC, 1'b1, 4'hF, 32'h2,         32'h0});
    vq.push_back('{3'd3, R_PRESC, 1'b0, 4'hF, 32'h0,         PS_EXP});
    vq.push_back('{3'd3, R_STAT,  1'b0, 4'hF, 32'h0,         32'h0});
    vq.push_back('{3'd3, R_CTRL,  1'b1, 4'hF, 32'h0,         32'h0});

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_ack",  128'(ack),    128'd0);
    chk("rst_dat",  128'(rdat),   128'd0);
    chk("rst_irq",  128'(irq),    128'd0);
    chk("rst_io",   128'(io_out), 128'd0);
    chk("rst_oeb",  128'(io_oeb), 128'd0);
    chk("rst_la",   la_out,       128'd0);

    foreach (vq[i]) begin
      xfer(vq[i].ch, vq[i].rg, vq[i].wr, vq[i].be,
           vq[i].wdata, q);
      if (!vq[i].wr)
        chk($sformatf("vec%0d", i), 128'(q), 128'(vq[i].exp));
    end

    // ch0 counts up to COMPARE=5, then stops.
    wr(3'd0, R_CMP, 32'd5);
    wr(3'd0, R_CTRL, 32'h1);
    prev = la_out[15:0];
    bad  = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      cur = la_out[15:0];
      if (!(cur == prev + 16'd1 ||
            (cur == 16'd5 && prev == 16'd5)))
        bad++;
      prev = cur;
    end
    chk("ch0_step", 128'(bad), 128'd0);
    chk("ch0_la_cnt", 128'(la_out[15:0]), 128'd5);
    chk("ch0_io", 128'(io_out), 128'd5);
    exp_la = '0;
    exp_la[15:0] = 16'd5;
    exp_la[64]   = 1'b1;
    chk("ch0_la_all", la_out, exp_la);
    rd(3'd0, R_CTRL, "ch0_en_clr", 32'h0);
    rd(3'd0, R_STAT, "ch0_match", 32'h1);
    rd(3'd0, R_COUNT, "ch0_hold", 32'd5);
    chk("ch0_noirq", 128'(irq), 128'd0);

    // ch1 down/auto-reload, single-stepped via LA freeze.
    @(negedge clk);
    la_oenb[0] = 1'b0;
    la_in[0]   = 1'b1;
    wr(3'd1, R_COUNT, 32'd2);
    wr(3'd1, R_CMP, 32'd0);
    wr(3'd1, R_CTRL, 32'hB);
    rd(3'd1, R_COUNT, "ch1_start", 32'd2);
    seq[0] = 16'd1; seq[1] = 16'd0; seq[2] = 16'hFFFF;
    for (int s = 0; s < 3; s++) begin
      step1();
      rd(3'd1, R_COUNT, $sformatf("ch1_seq%0d", s),
         32'(seq[s]));
    end
    rd(3'd1, R_STAT, "ch1_match", 32'h1);
    chk("ch1_noirq", 128'(irq), 128'd0);
    wr(3'd1, R_CTRL, 32'h0);

    // ch2 irq, W1C, set-wins and COUNT-write override.
    wr(3'd2, R_CMP, 32'd3);
    wr(3'd2, R_CTRL, 32'h7);
    @(negedge clk);
    la_in[0] = 1'b0;
    n = 0;
    while (!irq[0] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("ch2_irq_rise", 128'(irq), 128'd1);
    @(negedge clk);
    la_in[0] = 1'b1;
    wr(3'd2, R_STAT, 32'h1);
    rd(3'd2, R_STAT, "ch2_w1c", 32'h0);
    chk("ch2_irq_fall", 128'(irq), 128'd0);
    wr(3'd2, R_COUNT, 32'd3);
    coincide(3'd2, R_STAT, 32'h1);
    rd(3'd2, R_STAT, "ch2_set_wins", 32'h1);
    chk("ch2_irq_again", 128'(irq), 128'd1);
    rd(3'd2, R_COUNT, "ch2_reload", 32'd0);
    coincide(3'd2, R_COUNT, 32'h10);
    rd(3'd2, R_COUNT, "ch2_cnt_ovr", 32'h10);
    wr(3'd2, R_CTRL, 32'h0);
    wr(3'd2, R_STAT, 32'h1);

    // ch0 tick spacing, freeze gating, async reset.
    wr(3'd0, R_PRESC, 32'd2);
    wr(3'd0, R_CMP, 32'h100);
    wr(3'd0, R_COUNT, 32'd0);
    wr(3'd0, R_CTRL, 32'h1);
    @(negedge clk);
    la_in[0] = 1'b0;
    prev = la_out[15:0];
    bad  = 0;
    last = -1;
    nch  = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      cur = la_out[15:0];
      if (cur != prev) begin
        if (cur != prev + 16'd1) bad++;
        if (last >= 0 && c - last != GAP) bad++;
        last = c;
        nch++;
      end
      prev = cur;
    end
    chk("tick_gap", 128'(bad), 128'd0);
    chk("tick_seen", 128'(nch >= 4), 128'd1);
    @(negedge clk);
    la_in[0] = 1'b1;
    @(posedge clk); #1;
    snap = la_out[15:0];
    repeat (6) @(posedge clk);
    #1;
    chk("freeze_hold", 128'(la_out[15:0]), 128'(snap));
    @(negedge clk);
    la_oenb[0] = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("oenb_gates", 128'(la_out[15:0] != snap), 128'd1);

    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF;
    adr = {BASE[31:8], 3'd0, R_COUNT, 2'b00};
    #2;
    chk("pre_rst_cnt", 128'(la_out[15:0] != 16'd0), 128'd1);
    rst = 1'b1;
    #1;
    chk("arst_ack", 128'(ack),    128'd0);
    chk("arst_dat", 128'(rdat),   128'd0);
    chk("arst_irq", 128'(irq),    128'd0);
    chk("arst_io",  128'(io_out), 128'd0);
    chk("arst_la",  la_out,       128'd0);
    bad = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (ack !== 1'b0 || la_out !== '0) bad++;
    end
    chk("rst_drop", 128'(bad), 128'd0);
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rd(3'd0, R_CTRL,  "post_ctrl", 32'h0);
    rd(3'd0, R_COUNT, "post_cnt",  32'h0);
    rd(3'd0, R_CMP,   "post_cmp",  32'h0);
    rd(3'd0, R_PRESC, "post_ps",   32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/user_counter_array.md
USER_COUNTER_ARRAY -- requirements
Module: user_counter_array

Interface
REQ-001 SHALL have parameter NUM_CH, default 4 (legal 1..8), the number of independent counter channels.
REQ-002 SHALL have parameter CNT_W, default 16 (legal 8..32), the counter, compare and prescale-reload width.
REQ-003 SHALL have parameter IO_BITS, default 16 (legal 1..38), the number of io pads driven.
REQ-004 SHALL have parameter BASE_ADR, default 32'h3000_0000, the Wishbone base address; only bits [31:8] are used.
REQ-005 SHALL have the ports below; one clock, asynchronous active-high reset.
  - wb_clk_i  in  1  sole clock
  - wb_rst_i  in  1  asynchronous reset, active high
  - wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic slave controls
  - wbs_sel_i  in  4  byte enables
  - wbs_adr_i  in  32  address
  - wbs_dat_i  in  32  write data
  - wbs_ack_o  out  1  acknowledge
  - wbs_dat_o  out  32  read data
  - la_data_in  in  128  logic-analyzer data
  - la_oenb  in  128  logic-analyzer enables, active low
  - la_data_out  out  128  logic-analyzer observation
  - io_in  in  IO_BITS  unused
  - io_out  out  IO_BITS  pad outputs
  - io_oeb  out  IO_BITS  pad output enables, active low
  - irq  out  3  interrupt lines

Function
REQ-006 SHALL decode a hit when cyc&stb and wbs_adr_i[31:8]==BASE_ADR[31:8]; channel = adr[7:5], register = adr[4:2] (0 CTRL, 1 COUNT, 2 COMPARE, 3 STATUS, 4 PRESCALE).
REQ-007 SHALL assert wbs_ack_o for exactly one cycle, one cycle after a hit is first seen, then hold it low for at least one cycle before the next ack.
REQ-008 SHALL apply writes byte-wise per wbs_sel_i in the ack cycle; wbs_dat_o SHALL be valid in the ack cycle and 0 otherwise.
REQ-009 SHALL ack accesses to channel >= NUM_CH or register 5..7, read 0, and ignore the write.
REQ-010 CTRL bits: [0] enable, [1] auto_reload, [2] irq_en, [3] down (count direction); unused bits SHALL read 0.
REQ-011 An enabled channel SHALL step COUNT by 1 per tick (+1 up, -1 down), wrapping modulo 2^CNT_W.
REQ-012 When COUNT equals COMPARE on a tick, STATUS[0] (match) SHALL set; next value SHALL be 0 (up) or all-ones (down) if auto_reload, else COUNT holds and enable clears.
REQ-013 STATUS[0] SHALL be write-1-to-clear; if a set and a clear coincide, set wins.
REQ-014 A Wishbone write to COUNT SHALL override that cycle's tick.
REQ-015 irq[0] SHALL be the OR over channels of (match & irq_en), registered; irq[2:1] SHALL be 0.
REQ-016 When la_oenb[0]==0 and la_data_in[0]==1, all channels SHALL freeze (no tick; prescalers hold).
REQ-017 la_data_out[CNT_W-1:0] SHALL equal channel 0 COUNT; la_data_out[64+NUM_CH-1:64] SHALL equal the match flags; other bits SHALL be 0.
REQ-018 io_out SHALL equal channel 0 COUNT[IO_BITS-1:0] (zero-extended); io_oeb SHALL be all 0.

Reset
REQ-019 While wb_rst_i is high, all registers, counters, prescalers and flags SHALL be 0, and wbs_ack_o, wbs_dat_o, irq, io_out and la_data_out SHALL be 0, independent of the clock.
REQ-020 A Wishbone cycle in flight at reset SHALL be dropped without ack; the master retries.

Configuration
REQ-021 With macro USER_COUNTER_PRESCALE_EN defined: PRESCALE (CNT_W bits, RW) SHALL give one tick every PRESCALE+1 enabled cycles; the prescaler SHALL restart on a write to PRESCALE or COUNT.
REQ-022 Without USER_COUNTER_PRESCALE_EN: every enabled cycle SHALL be a tick; PRESCALE SHALL read 0 and ignore writes.

Verification
REQ-023 Reset, write ch0 CTRL=0x1, COMPARE=5 -> COUNT reaches 5, match=1, enable clears, COUNT holds 5.
REQ-024 ch1 CTRL=0xB (down, auto_reload, enable), COUNT=2, COMPARE=0 -> sequence 2,1,0,0xFFFF; match=1; irq[0] stays 0 (irq_en=0).
REQ-025 ch2 CTRL=0x7, COMPARE=3 -> irq[0]=1; W1C STATUS=1 in the same cycle as the next match -> flag stays 1.
REQ-026 Read from channel 6 with NUM_CH=4 -> ack after 1 cycle, wbs_dat_o=0; wbs_sel_i=4'b0001 write 0xAABBCCDD to COMPARE -> reads 0x00DD.
REQ-027 With the macro: PRESCALE=2, enable -> COUNT increments every 3 cycles; drive la_oenb[0]=0, la_data_in[0]=1 -> COUNT frozen; assert wb_rst_i mid-count -> all outputs 0 immediately.
